// File: rtl/usb_bus_arbiter_if.sv
// Requester handshakes and USB controller pad signals shared by usb_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters'/pads' view.
interface usb_bus_arbiter_if;
  logic        m0_rd;
  logic        m0_wr;
  logic [2:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ready;

  logic        m1_rd;
  logic        m1_wr;
  logic [2:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;

  logic [2:0]  bus_addr;
  logic        bus_cs_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_reset_n;
  logic [31:0] bus_dout;
  logic        bus_oe;
  logic [31:0] bus_din;

  modport slave (
    input  m0_rd, m0_wr, m0_addr, m0_wdata,
    input  m1_rd, m1_wr, m1_addr, m1_wdata,
    input  bus_din,
    output m0_rdata, m0_ready, m1_rdata, m1_ready,
    output bus_addr, bus_cs_n, bus_rd_n, bus_wr_n, bus_reset_n, bus_dout, bus_oe
  );

  modport master (
    output m0_rd, m0_wr, m0_addr, m0_wdata,
    output m1_rd, m1_wr, m1_addr, m1_wdata,
    output bus_din,
    input  m0_rdata, m0_ready, m1_rdata, m1_ready,
    input  bus_addr, bus_cs_n, bus_rd_n, bus_wr_n, bus_reset_n, bus_dout, bus_oe
  );
endinterface

// File: rtl/usb_bus_arbiter.sv
// Two-requester arbiter sequencing setup/strobe/hold/recovery accesses on the USB controller bus.
// Define USB_BUS_FIXED_PRIO_EN to give m0 fixed priority instead of round-robin.
module usb_bus_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 2,
  parameter int RESET_CYC   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  usb_bus_arbiter_if.slave bif
);

  localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_P = (MAX_ABCD > RESET_CYC) ? MAX_ABCD : RESET_CYC;
  localparam int CW = $clog2(MAX_P) + 1;

  // Counters load N-1 on state entry and the phase ends when they reach zero.
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RECOVER_LD = CW'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
  localparam logic [CW-1:0] RESET_LD   = CW'(RESET_CYC - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          gntM1_q;
  logic          dirWr_q;
  logic [31:0]   rdataCap_q;
  logic [31:0]   m0Rdata_q;
  logic [31:0]   m1Rdata_q;
  logic          m0Ready_q;
  logic          m1Ready_q;
  logic [2:0]    busAddr_q;
  logic          busCsN_q;
  logic          busRdN_q;
  logic          busWrN_q;
  logic          busResetN_q;
  logic [31:0]   busDout_q;
  logic          busOe_q;

  logic [1:0]    pend;
  logic          pickM1;
  logic [2:0]    pickAddr;
  logic [31:0]   pickWdata;
  logic          pickWr;

  assign pend = {bif.m1_rd | bif.m1_wr, bif.m0_rd | bif.m0_wr};

`ifdef USB_BUS_FIXED_PRIO_EN
  assign pickM1 = ~pend[0];
`else
  // rrLast_q records the requester served last; the other one wins a tie.
  logic rrLast_q;
  assign pickM1 = pend[1] & (~pend[0] | ~rrLast_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrLast_q <= 1'b1;
    end else if (state_q == ST_IDLE && pend != 2'b00) begin
      rrLast_q <= pickM1;
    end
  end
`endif

  assign pickAddr  = pickM1 ? bif.m1_addr  : bif.m0_addr;
  assign pickWdata = pickM1 ? bif.m1_wdata : bif.m0_wdata;
  assign pickWr    = pickM1 ? bif.m1_wr    : bif.m0_wr;

  // Sequencer: every bus control and completion output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= RESET_LD;
      gntM1_q     <= 1'b0;
      dirWr_q     <= 1'b0;
      rdataCap_q  <= '0;
      m0Rdata_q   <= '0;
      m1Rdata_q   <= '0;
      m0Ready_q   <= 1'b0;
      m1Ready_q   <= 1'b0;
      busAddr_q   <= '0;
      busCsN_q    <= 1'b1;
      busRdN_q    <= 1'b1;
      busWrN_q    <= 1'b1;
      busResetN_q <= 1'b0;
      busDout_q   <= '0;
      busOe_q     <= 1'b0;
    end else begin
      m0Ready_q <= 1'b0;
      m1Ready_q <= 1'b0;
      case (state_q)
        ST_RST: begin
          if (cnt_q == '0) begin
            busResetN_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (pend != 2'b00) begin
            gntM1_q   <= pickM1;
            dirWr_q   <= pickWr;
            busAddr_q <= pickAddr;
            busDout_q <= pickWdata;
            busOe_q   <= pickWr;
            busCsN_q  <= 1'b0;
            cnt_q     <= SETUP_LD;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            busRdN_q <= dirWr_q;
            busWrN_q <= ~dirWr_q;
            cnt_q    <= STROBE_LD;
            state_q  <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            busRdN_q <= 1'b1;
            busWrN_q <= 1'b1;
            if (!dirWr_q) begin
              rdataCap_q <= bif.bus_din;
            end
            // A single hold cycle means the ready pulse starts on this same edge.
            if (HOLD_CYC == 1) begin
              if (gntM1_q) begin
                m1Ready_q <= 1'b1;
                if (!dirWr_q) m1Rdata_q <= bif.bus_din;
              end else begin
                m0Ready_q <= 1'b1;
                if (!dirWr_q) m0Rdata_q <= bif.bus_din;
              end
            end
            cnt_q   <= HOLD_LD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == CNT_ONE) begin
            if (gntM1_q) begin
              m1Ready_q <= 1'b1;
              if (!dirWr_q) m1Rdata_q <= rdataCap_q;
            end else begin
              m0Ready_q <= 1'b1;
              if (!dirWr_q) m0Rdata_q <= rdataCap_q;
            end
          end
          if (cnt_q == '0) begin
            busCsN_q <= 1'b1;
            busOe_q  <= 1'b0;
            if (RECOVER_CYC == 0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= RECOVER_LD;
              state_q <= ST_RECOVER;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RECOVER: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bif.m0_rdata    = m0Rdata_q;
  assign bif.m1_rdata    = m1Rdata_q;
  assign bif.m0_ready    = m0Ready_q;
  assign bif.m1_ready    = m1Ready_q;
  assign bif.bus_addr    = busAddr_q;
  assign bif.bus_cs_n    = busCsN_q;
  assign bif.bus_rd_n    = busRdN_q;
  assign bif.bus_wr_n    = busWrN_q;
  assign bif.bus_reset_n = busResetN_q;
  assign bif.bus_dout    = busDout_q;
  assign bif.bus_oe      = busOe_q;

endmodule
